// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared WISC-S15 definitions: opcodes, widths, NOP, fetch states
package fetch_stage_pkg;

    localparam int PC_W = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Saturating 16-bit increment for the fetch performance counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: control inputs, imem port, IF/ID outputs (FETCH_PERF_CNT_EN adds counters)
interface fetch_stage_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] im_addr;
    logic            im_rd_en;
    logic [PC_W-1:0] im_instr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] if_id_instr;
    logic [PC_W-1:0] if_id_pc_plus1;
    logic            if_id_valid;
    logic            fetch_halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]     perf_fetched;
    logic [15:0]     perf_stalled;
    logic [15:0]     perf_flushed;
`endif

    modport master (
        input  stall, redirect_valid, redirect_pc, im_instr,
        output im_addr, im_rd_en, pc, if_id_instr, if_id_pc_plus1, if_id_valid, fetch_halted
`ifdef FETCH_PERF_CNT_EN
        , output perf_fetched, perf_stalled, perf_flushed
`endif
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, im_instr,
        input  im_addr, im_rd_en, pc, if_id_instr, if_id_pc_plus1, if_id_valid, fetch_halted
`ifdef FETCH_PERF_CNT_EN
        , input perf_fetched, perf_stalled, perf_flushed
`endif
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with clear, load, bubble and hold
module if_id_reg #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [PC_W-1:0] i_instr,
    input  logic [PC_W-1:0] i_pc_plus1,
    output logic [PC_W-1:0] o_instr,
    output logic [PC_W-1:0] o_pc_plus1,
    output logic            o_valid
);
    logic [PC_W-1:0] r_instr;
    logic [PC_W-1:0] r_pc_plus1;
    logic            r_valid;

    // Priority clear > load > bubble > hold; a bubble keeps the payload, only drops valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (i_clear) begin
            r_instr    <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus1 <= i_pc_plus1;
            r_valid    <= 1'b1;
        end else if (i_bubble) begin
            r_valid    <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - WISC-S15 fetch stage: PC, HLT state, IF/ID; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W        = fetch_stage_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]      HALT_OPCODE = fetch_stage_pkg::OP_HLT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;

    logic [PC_W-1:0] w_pc_plus1;
    logic            w_is_hlt;
    logic            w_clear;
    logic            w_load;
    logic            w_bubble;

    assign w_pc_plus1 = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_is_hlt   = (bus.im_instr[PC_W-1 -: 4] == HALT_OPCODE);

    // Redirect beats stall; a stalled cycle neither latches nor detects HLT
    assign w_clear  = bus.redirect_valid;
    assign w_load   = !bus.redirect_valid && !bus.stall && (r_state == ST_RUN);
    assign w_bubble = !bus.redirect_valid && !bus.stall && (r_state == ST_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_state <= ST_RUN;
        end else if (w_load) begin
            if (w_is_hlt) begin
                r_state <= ST_HALTED;
            end else begin
                r_pc    <= w_pc_plus1;
            end
        end
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_instr    (bus.im_instr),
        .i_pc_plus1 (w_pc_plus1),
        .o_instr    (bus.if_id_instr),
        .o_pc_plus1 (bus.if_id_pc_plus1),
        .o_valid    (bus.if_id_valid)
    );

    assign bus.im_addr      = r_pc;
    assign bus.pc           = r_pc;
    assign bus.im_rd_en     = (r_state == ST_RUN);
    assign bus.fetch_halted = (r_state == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stalled;
    logic [15:0] r_perf_flushed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= 16'd0;
            r_perf_stalled <= 16'd0;
            r_perf_flushed <= 16'd0;
        end else begin
            if (w_load)
                r_perf_fetched <= sat_inc16(r_perf_fetched);
            if (bus.stall && !bus.redirect_valid)
                r_perf_stalled <= sat_inc16(r_perf_stalled);
            if (bus.redirect_valid)
                r_perf_flushed <= sat_inc16(r_perf_flushed);
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_stalled = r_perf_stalled;
    assign bus.perf_flushed = r_perf_flushed;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined WISC-S15 CPU. It sits directly upstream of decode, control and the register file.
- Owns the architectural PC and drives the instruction memory address.
- Latches the fetched instruction and PC+1 into IF/ID; PC+1 is later used as the call link value.
- Honours stall from the hazard unit and redirect from branch/call/ret resolution, and stops fetching after a HLT is fetched.

Parameters:
- PC_W, 16, width of PC and instruction word.
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that denotes HLT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect_valid  in  1  control transfer resolved this cycle.
- redirect_pc  in  PC_W  target for redirect.
- im_addr  out  PC_W  instruction memory address; equals pc combinationally.
- im_rd_en  out  1  instruction memory read enable.
- im_instr  in  PC_W  instruction at im_addr, combinational same-cycle read.
- pc  out  PC_W  current fetch PC.
- if_id_instr  out  PC_W  registered instruction to decode.
- if_id_pc_plus1  out  PC_W  registered pc+1 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_halted  out  1  fetch stopped on HLT.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n=0 including mid-operation:
  - pc=RESET_PC
  - if_id_instr=0, if_id_pc_plus1=0, if_id_valid=0
  - state=RUN, fetch_halted=0
- States: RUN and HALTED.
- Combinational outputs: im_addr=pc; im_rd_en=(state==RUN); fetch_halted=(state==HALTED).
- Per-cycle priority: redirect_valid > stall > normal.
- Redirect (any state):
  - pc<=redirect_pc.
  - if_id_valid<=0, if_id_instr<=0, if_id_pc_plus1<=0.
  - state<=RUN. A redirect un-halts, because a HLT on the wrong path is squashed.
- Stall (no redirect): pc, all IF/ID registers and state hold. No halt detection happens in a stalled cycle.
- Normal RUN:
  - if_id_instr<=im_instr, if_id_pc_plus1<=pc+1, if_id_valid<=1.
  - If im_instr[15:12]==HALT_OPCODE: pc holds and state<=HALTED. The HLT itself is still passed down with valid=1.
  - Otherwise pc<=pc+1.
- Normal HALTED: pc holds; if_id_valid<=0 (bubbles); instr/pc_plus1 registers hold their values.
- Arithmetic: pc+1 is modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000 for both pc and if_id_pc_plus1.
- Latency: an instruction at address A appears on if_id_* one cycle after pc==A, absent stall or redirect.
- Redirect to the current pc is legal: it still inserts one bubble.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds three 16-bit outputs.
  - perf_fetched: increments on each normal RUN latch.
  - perf_stalled: increments on each stall cycle without redirect.
  - perf_flushed: increments on each redirect cycle.
  - All three reset to 0 and saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (wisc_defs) holds:
  - opcode constants, including OP_HLT=4'hF
  - PC_W
  - NOP encoding 16'h0000
  - state encodings ST_RUN=1'b0, ST_HALTED=1'b1
- One natural sub-module, if_id_reg: the IF/ID register with load, hold and clear inputs. It pairs with the existing mem_wb_reg.
- PC and state logic stay in fetch_stage.

Test Plan:
- Reset then free-run with memory words 0x1123, 0x2234, 0x3345 at addresses 0–2 → pc goes 0,1,2,3. At the cycle pc=1, if_id_instr=0x1123, if_id_pc_plus1=1, if_id_valid=1.
- stall=1 for 2 cycles while pc=2 → pc stays 2 and if_id_instr/valid are unchanged. After release, the word at address 2 is latched and pc=3.
- redirect_valid=1, redirect_pc=0x0040, with stall=1 in the same cycle → next pc=0x0040 and if_id_valid=0. The following cycle latches mem[0x40] with if_id_pc_plus1=0x0041.
- HLT 0xF000 at address 5 → IF/ID shows 0xF000 with valid=1, and pc stays 5. fetch_halted=1 and im_rd_en=0. Subsequent cycles have if_id_valid=0.
- HALTED, then redirect_pc=0x0010 → state returns to RUN, fetch_halted=0 and pc=0x0010.
- pc=16'hFFFF with a non-HLT word, then assert rst_n=0 mid-cycle:
  - before reset: next pc=0x0000 and if_id_pc_plus1=0x0000
  - on reset assertion: all outputs return to reset values immediately, without waiting for clk.
